eth_tx_fcs: RTL and testbench
=============================

# eth_tx_fcs

Transmit frame assembler for the Ethernet TX path. It sits on the bus-clock side, directly upstream of the frame buffer's write port. It accepts frame payload bytes from the bus register interface and forwards each one to the buffer. On end-of-frame it optionally zero-pads the frame to the Ethernet minimum, then appends the 4-byte CRC-32 FCS, so that the serializer transmits a complete, valid frame after the preloaded preamble/SFD.

## Interface
- MIN_LEN, 60, minimum frame length before FCS, in bytes; padding target.
- MAX_LEN, 244, maximum accepted data bytes; 244 data + 4 FCS + 8 preamble = 256-byte buffer.
- LEN_W, 8, width of the length counter and of `len`.
- a_clk  in  1  bus clock (HCLK domain).
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- s_close  in  1  end-of-frame request, single-cycle pulse.
- s_clr  in  1  flush; aborts the frame (driven from the TX_FLUSH command bit).
- m_wr  out  1  write strobe to the frame buffer write port.
- m_din  out  8  byte to the frame buffer.
- busy  out  1  pad/FCS emission in progress.
- done  out  1  one-cycle pulse: frame complete in buffer.
- len  out  LEN_W  bytes written this frame, including pad and FCS; valid while done is high and held until the next s_clr.

## Operation
- States: IDLE, DATA, PAD, FCS, DONE.
- IDLE: crc=32'hFFFFFFFF, cnt=0, s_ready=1. An accepted byte moves to DATA. s_close in IDLE with no byte goes to PAD (or to FCS if padding is compiled out).
- DATA: each accepted byte updates the CRC and increments cnt, and the byte is emitted on m_wr/m_din.
  - s_ready=0 once cnt==MAX_LEN; further bytes are back-pressured, not dropped.
- s_close in DATA or IDLE:
  - cnt<MIN_LEN: go to PAD.
  - otherwise: go to FCS.
  - A byte accepted in the same cycle as s_close counts as the last data byte.
- PAD: emit 8'h00 once per cycle, each folded into the CRC, until cnt==MIN_LEN; then go to FCS. s_ready=0.
- FCS: emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24] over 4 consecutive cycles. The CRC is frozen on entry. Then go to DONE.
- DONE: done=1 for one cycle, len=cnt+4; return to IDLE.
- CRC-32: reflected polynomial 32'hEDB88320, LSB-first bitwise update over 8 bits per byte, init all-ones. The complemented result is the FCS.
- s_clr: highest priority in every state. Next cycle the block is IDLE with the CRC re-initialised, cnt=0, len=0, and no m_wr. A half-emitted FCS is abandoned.
- s_close while busy or in DONE is ignored.

## Timing
- Reset values: s_ready=1, m_wr=0, m_din=0, busy=0, done=0, len=0; state IDLE.
- m_wr/m_din are registered: a byte accepted in cycle N is written in cycle N+1. Pad and FCS bytes follow back-to-back with no gaps.
- busy is high from the cycle after s_close acceptance through the last FCS write.
- done rises one cycle after the last FCS m_wr.
- Throughput is 1 byte/cycle.
- Reset mid-frame acts immediately (asynchronous); no partial write is emitted after reset release.

## Configuration
- ETH_TX_PAD_EN defined: PAD state is present and short frames are zero-padded to MIN_LEN.
- ETH_TX_PAD_EN undefined: no PAD state. s_close always goes straight to FCS, and len = data bytes + 4.

## Structure
- Shared package eth_pkg holds CRC_POLY, CRC_INIT, MIN_LEN/MAX_LEN defaults, and the state encoding constants.
- One sub-module, eth_crc32: a CRC register with init/update/hold controls, 8-bit data in, 32-bit crc out.

## Test plan
- Bytes "123456789" (31..39) then s_close, padding off → FCS bytes 26,39,F4,CB; len=13; done 1 cycle after the last write.
- Same 9 bytes with ETH_TX_PAD_EN → 51 zero pad bytes, then 4 FCS bytes that match a reference model over 60 bytes; len=64.
- 244 bytes streamed with s_valid held high → s_ready drops after byte 244, the 245th is held not dropped; s_close → 4 FCS bytes, len=248.
- s_close pulsed in the same cycle as the final byte → that byte is included in the CRC and cnt; the FCS follows immediately.
- s_clr asserted during the second FCS byte → m_wr low next cycle, no done; the next frame "123456789" still yields 26,39,F4,CB.
- rst asserted mid-DATA → all outputs go to reset values at once; after release the first frame is correct.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, state encoding and CRC-32 byte step for the Ethernet TX path.
package eth_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam int          ETH_MIN_LEN = 60;
    localparam int          ETH_MAX_LEN = 244;
    localparam int          ETH_LEN_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_FCS  = 3'd3,
        ST_DONE = 3'd4
    } tx_state_e;

    // Reflected CRC-32, one byte folded in LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// CRC-32 register with init/update/hold control; init wins over update.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        a_clk,
    input  logic        rst,
    input  logic        init,
    input  logic        update,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (update) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_ff @(posedge a_clk or negedge rst) begin
        if (!rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_fcs.sv
// TX frame assembler: forwards payload bytes, zero-pads short frames when
// ETH_TX_PAD_EN is defined, then appends the 4-byte CRC-32 FCS.
module eth_tx_fcs
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int LEN_W   = ETH_LEN_W
) (
    input  logic             a_clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic             s_close,
    input  logic             s_clr,
    output logic             m_wr,
    output logic [7:0]       m_din,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] len
);

    localparam logic [LEN_W-1:0] MIN_CNT = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    tx_state_e        state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       fcs_idx_q, fcs_idx_d;
    logic             m_wr_q, m_wr_d;
    logic [7:0]       m_din_q, m_din_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             crc_init;
    logic             crc_upd;
    logic [7:0]       crc_data;
    logic [31:0]      crc;
    logic [31:0]      fcs_word;
    logic             accept;
    logic [LEN_W-1:0] cnt_acc;

    eth_crc32 u_crc (
        .a_clk  (a_clk),
        .rst    (rst),
        .init   (crc_init),
        .update (crc_upd),
        .data   (crc_data),
        .crc    (crc)
    );

    // s_valid/s_ready: a byte transfers in any cycle where both are high;
    // s_ready never depends on s_valid or s_close.
    assign s_ready  = ((state_q == ST_IDLE) || (state_q == ST_DATA)) && (cnt_q < MAX_CNT);
    assign accept   = s_valid && s_ready;
    assign fcs_word = ~crc;
    assign cnt_acc  = cnt_q + LEN_W'(accept);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        fcs_idx_d = fcs_idx_q;
        m_wr_d    = 1'b0;
        m_din_d   = m_din_q;
        done_d    = 1'b0;
        crc_init  = 1'b0;
        crc_upd   = 1'b0;
        crc_data  = s_data;

        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    m_wr_d  = 1'b1;
                    m_din_d = s_data;
                    crc_upd = 1'b1;
                    cnt_d   = cnt_acc;
                    state_d = ST_DATA;
                end
                // A byte taken alongside s_close is already in cnt_acc.
                if (s_close) begin
`ifdef ETH_TX_PAD_EN
                    state_d = (cnt_acc < MIN_CNT) ? ST_PAD : ST_FCS;
`else
                    state_d = ST_FCS;
`endif
                end
            end
`ifdef ETH_TX_PAD_EN
            ST_PAD: begin
                m_wr_d   = 1'b1;
                m_din_d  = 8'h00;
                crc_upd  = 1'b1;
                crc_data = 8'h00;
                cnt_d    = cnt_q + LEN_W'(1);
                if (cnt_d == MIN_CNT) begin
                    state_d = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                m_wr_d    = 1'b1;
                m_din_d   = fcs_word[8*fcs_idx_q +: 8];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                len_d    = cnt_q + LEN_W'(4);
                cnt_d    = '0;
                crc_init = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (s_clr) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            len_d     = '0;
            fcs_idx_d = '0;
            m_wr_d    = 1'b0;
            done_d    = 1'b0;
            crc_init  = 1'b1;
            crc_upd   = 1'b0;
        end

        // DONE is the cycle the final FCS byte is on m_wr, so it still counts as busy.
        busy_d = (state_d == ST_PAD) || (state_d == ST_FCS) || (state_d == ST_DONE);
    end

    always_ff @(posedge a_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            fcs_idx_q <= '0;
            m_wr_q    <= 1'b0;
            m_din_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            fcs_idx_q <= fcs_idx_d;
            m_wr_q    <= m_wr_d;
            m_din_q   <= m_din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign m_wr  = m_wr_q;
    assign m_din = m_din_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign len   = len_q;

endmodule

// File: tb/tb_eth_tx_fcs.sv
// Self-checking bench for eth_tx_fcs: vector table, random frames against a
// frame-level CRC model, and hand sequences for max length, flush and reset.
module tb_eth_tx_fcs;

    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 244;

    logic       a_clk   = 1'b0;
    logic       rst     = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_close = 1'b0;
    logic       s_clr   = 1'b0;
    logic       s_ready;
    logic       m_wr;
    logic [7:0] m_din;
    logic       busy;
    logic       done;
    logic [7:0] len;

    eth_tx_fcs dut (
        .a_clk   (a_clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .s_close (s_close),
        .s_clr   (s_clr),
        .m_wr    (m_wr),
        .m_din   (m_din),
        .busy    (busy),
        .done    (done),
        .len     (len)
    );

    always #5 a_clk = ~a_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic       rdy_s, m_wr_s, busy_s, done_s;
    logic [7:0] len_s;
    int         done_n, done_gap, last_wr_cyc, first_wr_cyc;
    logic [7:0] done_len;
    logic       done_busy;

    typedef struct {
        int n;
        bit close_last;
        int exp_len;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int got_at(input int k);
        if (k < got_q.size()) return int'(got_q[k]);
        return -1;
    endfunction

    task automatic sample();
        cyc++;
        rdy_s  = s_ready;
        m_wr_s = m_wr;
        busy_s = busy;
        done_s = done;
        len_s  = len;
        if (m_wr) begin
            if (got_q.size() == 0) first_wr_cyc = cyc;
            got_q.push_back(m_din);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_gap  = cyc - last_wr_cyc;
            done_len  = len;
            done_busy = busy;
        end
    endtask

    task automatic cycle();
        @(negedge a_clk);
        sample();
        @(posedge a_clk);
        #1;
    endtask

    // Frame model: data, optional zero pad to MIN_LEN, then bit-serial CRC-32 complemented, LSB byte first.
    task automatic build_expected();
        logic [31:0] c;
        exp_q = frame_q;
`ifdef ETH_TX_PAD_EN
        while (exp_q.size() < MIN_LEN) exp_q.push_back(8'h00);
`endif
        c = 32'hFFFFFFFF;
        foreach (exp_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ exp_q[k][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic drive_bytes(input string tag, input bit close_last, input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < frame_q.size() && guard < 2000) begin
            guard++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_close = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = frame_q[i];
                s_close = close_last && (i == frame_q.size() - 1);
            end
            cycle();
            if (s_valid && rdy_s) i++;
        end
        check({tag, "_accepted"}, i, frame_q.size());
        if (!close_last || frame_q.size() == 0) begin
            s_valid = 1'b0;
            s_close = 1'b1;
            cycle();
        end
        s_valid = 1'b0;
        s_close = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        cycle();
        check({tag, "_busy_after_close"}, busy_s, 1);
        while (done_n == 0 && g < 600) begin
            cycle();
            g++;
        end
        check({tag, "_done_seen"}, done_n, 1);
        cycle();
        check({tag, "_len_hold"}, len_s, exp_q.size());
    endtask

    task automatic compare(input string tag, input bit contiguous);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
        check({tag, "_len"}, done_len, exp_q.size());
        check({tag, "_done_gap"}, done_gap, 1);
        check({tag, "_done_busy"}, done_busy, 0);
        if (contiguous)
            check({tag, "_contig"}, last_wr_cyc - first_wr_cyc + 1, exp_q.size());
    endtask

    task automatic run_frame(input string tag, input bit close_last, input bit gaps);
        got_q.delete();
        done_n = 0;
        build_expected();
        drive_bytes(tag, close_last, gaps);
        wait_done(tag);
        compare(tag, close_last && !gaps);
    endtask

    task automatic known_frame(input string tag);
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        run_frame(tag, 1'b0, 1'b0);
`ifdef ETH_TX_PAD_EN
        check({tag, "_len64"}, done_len, 64);
        check({tag, "_pad_first"}, got_at(9), 0);
        check({tag, "_pad_last"}, got_at(59), 0);
`else
        check({tag, "_len13"}, done_len, 13);
        check({tag, "_fcs0"}, got_at(9), 'h26);
        check({tag, "_fcs1"}, got_at(10), 'h39);
        check({tag, "_fcs2"}, got_at(11), 'hF4);
        check({tag, "_fcs3"}, got_at(12), 'hCB);
`endif
    endtask

    initial begin
        int i;
        int g;

`ifdef ETH_TX_PAD_EN
        vecs = '{'{0, 1'b0, 64}, '{1, 1'b1, 64}, '{9, 1'b1, 64}, '{59, 1'b1, 64},
                 '{60, 1'b0, 64}, '{61, 1'b1, 65}, '{100, 1'b0, 104}};
`else
        vecs = '{'{0, 1'b0, 4}, '{1, 1'b1, 5}, '{9, 1'b1, 13}, '{59, 1'b1, 63},
                 '{60, 1'b0, 64}, '{61, 1'b1, 65}, '{100, 1'b0, 104}};
`endif

        // Reset state, reset held from time zero.
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_wr", m_wr, 0);
        check("rst_m_din", m_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len", len, 0);
        repeat (3) @(posedge a_clk);
        @(negedge a_clk);
        rst = 1'b1;
        @(posedge a_clk);
        #1;

        known_frame("known");

        foreach (vecs[r]) begin
            frame_q.delete();
            for (int k = 0; k < vecs[r].n; k++) frame_q.push_back(8'(r * 37 + k * 13 + 5));
            run_frame($sformatf("vec%0d", r), vecs[r].close_last, 1'b0);
            check($sformatf("vec%0d_tbl_len", r), done_len, vecs[r].exp_len);
        end

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(0, MAX_LEN);
            frame_q.delete();
            for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
            run_frame($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Maximum frame with s_valid held high past the limit.
        frame_q.delete();
        for (int k = 0; k < MAX_LEN; k++) frame_q.push_back(8'($urandom));
        got_q.delete();
        done_n = 0;
        build_expected();
        i = 0;
        g = 0;
        s_valid = 1'b1;
        while (i < MAX_LEN && g < 400) begin
            s_data = frame_q[i];
            cycle();
            if (rdy_s) i++;
            g++;
        end
        check("max_accepted", i, MAX_LEN);
        s_data = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("max_ready_low%0d", k), rdy_s, 0);
        end
        s_valid = 1'b0;
        s_close = 1'b1;
        cycle();
        s_close = 1'b0;
        wait_done("max");
        compare("max", 1'b0);
        check("max_len248", done_len, 248);

        // Flush while the second FCS byte is on the write port.
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        got_q.delete();
        done_n = 0;
        build_expected();
        drive_bytes("clr", 1'b1, 1'b0);
        g = 0;
        while (g < 200) begin
            @(negedge a_clk);
            sample();
            g++;
            if (got_q.size() == exp_q.size() - 2) s_clr = 1'b1;
            @(posedge a_clk);
            #1;
            if (s_clr) break;
        end
        check("clr_reached_fcs1", s_clr, 1);
        s_clr = 1'b0;
        cycle();
        check("clr_no_wr", m_wr_s, 0);
        repeat (10) cycle();
        check("clr_no_done", done_n, 0);
        check("clr_len", len_s, 0);
        check("clr_busy", busy_s, 0);
        check("clr_written", got_q.size(), exp_q.size() - 2);
        known_frame("after_clr");

        // Asynchronous reset in the middle of payload.
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            cycle();
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_s_ready", s_ready, 1);
        check("arst_m_wr", m_wr, 0);
        check("arst_m_din", m_din, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_len", len, 0);
        s_valid = 1'b0;
        repeat (2) @(posedge a_clk);
        @(negedge a_clk);
        rst = 1'b1;
        @(posedge a_clk);
        #1;
        got_q.delete();
        repeat (3) cycle();
        check("arst_no_wr", got_q.size(), 0);
        known_frame("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
